// File: rtl/dm_byteen_ram.sv
// dm_byteen_ram: byte-enabled data memory with post-reset clear sweep and store-commit log
module dm_byteen_ram #(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        busy,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        err_oob
);
  localparam int DEPTH = 2 ** AW;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx, wa;
  logic [31:0] cur, merged, wd;
  logic ready, oob, store, we;
  logic log_valid_q, log_valid_d, err_oob_q, err_oob_d;
  logic [31:0] log_pc_q, log_pc_d, log_addr_q, log_addr_d, log_data_q, log_data_d;
  always_comb begin
    idx = m_data_addr[AW+1:2];
    oob = |m_data_addr[31:AW+2];
    cur = mem[idx];
    for (int i = 0; i < 4; i++) merged[8*i+:8] = m_data_byteen[i] ? m_data_wdata[8*i+:8] : cur[8*i+:8];
    ready = state_q == READY;
    store = ready && |m_data_byteen && !oob;
    state_d = (!ready && clr_ptr_q == AW'(DEPTH - 1)) ? READY : state_q;
    clr_ptr_d = ready ? clr_ptr_q : clr_ptr_q + AW'(1);
    // reset keeps zeroing word 0 so a held reset leaves the sweep origin clean
    we = reset || !ready || store;
    wa = reset ? '0 : ready ? idx : clr_ptr_q;
    wd = (ready && !reset) ? merged : '0;
    log_valid_d = store;
    err_oob_d = ready && |m_data_byteen && oob;
    log_pc_d = store ? m_inst_addr : log_pc_q;
    log_addr_d = store ? (m_data_addr & 32'hffff_fffc) : log_addr_q;
    log_data_d = store ? merged : log_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      log_valid_q <= 1'b0;
      err_oob_q <= 1'b0;
      log_pc_q <= '0;
      log_addr_q <= '0;
      log_data_q <= '0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      log_valid_q <= log_valid_d;
      err_oob_q <= err_oob_d;
      log_pc_q <= log_pc_d;
      log_addr_q <= log_addr_d;
      log_data_q <= log_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  assign m_data_rdata = (ready && !oob) ? cur : '0;
  assign busy = !ready;
  assign log_valid = log_valid_q;
  assign err_oob = err_oob_q;
  assign log_pc = log_pc_q;
  assign log_addr = log_addr_q;
  assign log_data = log_data_q;
endmodule

// File: tb/tb_dm_byteen_ram.sv
// tb_dm_byteen_ram: randomized scoreboard bench for dm_byteen_ram with AW=4
module tb_dm_byteen_ram;
  logic clk = 0, reset = 1;
  logic [31:0] m_data_addr = 0, m_data_wdata = 0, m_inst_addr = 0;
  logic [3:0] m_data_byteen = 0;
  logic [31:0] m_data_rdata, log_pc, log_addr, log_data;
  logic busy, log_valid, err_oob;
  int checks = 0, errors = 0;
  typedef struct {bit err; logic [31:0] pc, addr, data;} ev_t;
  ev_t q[$];
  logic [31:0] model [16];

  dm_byteen_ram #(.AW(4)) dut (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
    .busy(busy), .log_valid(log_valid), .log_pc(log_pc), .log_addr(log_addr),
    .log_data(log_data), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (log_valid === 1'b1 || err_oob === 1'b1) begin
        if (q.size() == 0) chk("unexpected_event", {30'b0, err_oob, log_valid}, 32'h0);
        else begin
          e = q.pop_front();
          if (e.err) begin
            chk("err_oob", 32'(err_oob), 32'h1);
            chk("oob_log_valid", 32'(log_valid), 32'h0);
          end else begin
            chk("log_valid", 32'(log_valid), 32'h1);
            chk("log_pc", log_pc, e.pc);
            chk("log_addr", log_addr, e.addr);
            chk("log_data", log_data, e.data);
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return (a >= 32'd64) ? 32'h0 : model[a[5:2]];
  endfunction

  task automatic do_reset(input int n);
    reset = 1;
    m_data_byteen = 0;
    repeat (n) @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 16; i++) model[i] = 0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] pc);
    logic [31:0] old, mrg;
    ev_t e;
    m_data_addr = a;
    m_data_wdata = wdata;
    m_data_byteen = be;
    m_inst_addr = pc;
    old = ref_read(a);
    mrg = old;
    for (int i = 0; i < 4; i++) if (be[i]) mrg[8*i+:8] = wdata[8*i+:8];
    if (be != 0) begin
      e.err = a >= 32'd64;
      e.pc = pc;
      e.addr = a & 32'hffff_fffc;
      e.data = mrg;
      q.push_back(e);
    end
    @(negedge clk);
    chk("rdata_during_op", m_data_rdata, old);
    @(posedge clk);
    #1 m_data_byteen = 0;
    if (be != 0 && a < 32'd64) model[a[5:2]] = mrg;
  endtask

  task automatic rd(input string name, input logic [31:0] a);
    m_data_addr = a;
    m_data_byteen = 0;
    @(negedge clk);
    chk(name, m_data_rdata, ref_read(a));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [31:0] a;
    fork monitor(); join_none
    do_reset(2);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_log_valid", 32'(log_valid), 32'h0);
    chk("rst_err_oob", 32'(err_oob), 32'h0);
    chk("rst_log_pc", log_pc, 32'h0);
    chk("rst_log_addr", log_addr, 32'h0);
    chk("rst_log_data", log_data, 32'h0);
    wait_sweep(n);
    chk("sweep1_len", 32'(n), 32'd16);
    chk("ready_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 16; i++) op(32'(i * 4), 32'hdeadbeef, 4'hf, $urandom);
    rd("preload", 32'h24);
    do_reset(1);
    wait_sweep(n);
    chk("sweep2_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) rd("cleared_word", 32'(i * 4));
    op(32'h8, 32'h11223344, 4'hf, 32'h0040_0100);
    op(32'h8, 32'h0000aa00, 4'b0010, 32'h0040_0104);
    rd("merge_read", 32'h8);
    chk("merge_model", model[2], 32'h1122aa44);
    op(32'hc, 32'h5a5a_1234, 4'hf, 32'h0040_0200);
    rd("same_cycle_new", 32'hc);
    op(32'h0, 32'hcafef00d, 4'hf, 32'h0040_0300);
    op(32'h40, 32'h12345678, 4'hf, 32'h0040_0304);
    rd("oob_read", 32'h40);
    rd("no_alias_word0", 32'h0);
    for (int k = 0; k < 200; k++) begin
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) rd("rand_read", a);
      else op(a, $urandom, 4'($urandom), $urandom);
    end
    do_reset(1);
    repeat (2) @(posedge clk);
    #1;
    m_data_addr = 32'h4;
    m_data_wdata = 32'h55aa55aa;
    m_data_byteen = 4'hf;
    @(negedge clk);
    chk("clear_rdata_forced", m_data_rdata, 32'h0);
    chk("clear_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1 m_data_byteen = 0;
    wait_sweep(n);
    chk("sweep3_rest", 32'(n), 32'd13);
    rd("dropped_store", 32'h4);
    do_reset(1);
    repeat (8) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    wait_sweep(n);
    chk("sweep_restart_len", 32'(n), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
